// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : lsu_bus_bridge
// Description : Load/store bridge between the single-cycle RV32I core's
//               data-memory port and a word-aligned valid/ready bus.
//               Shifts store data/strobes into the addressed byte lanes,
//               right-aligns and zero-fills load data, stalls the core for
//               the duration of the access, and flags misaligned accesses
//               and bus timeouts.
// Ports       : clk, nreset (sync, active-low)
//               cpu_*  : core side (req/we/addr/wdata/wstrobe in;
//                        rdata/stall/err out), err_sticky out
//               bus_*  : bus side (req_valid/addr/we/wdata/wstrb out,
//                        req_ready in; rsp_valid/rdata in)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrobe,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        err_sticky,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t             state_q, state_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [3:0]         bus_wstrb_q, bus_wstrb_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               tout_q, tout_d;
    logic               err_sticky_q, err_sticky_d;

    logic [1:0]         req_size;
    logic [3:0]         req_strb;
    logic               misaligned;
    logic [31:0]        rsp_shifted;
    logic [31:0]        load_data;
    logic [CNT_W-1:0]   cnt_inc;
    logic               tout_hit;

    // Size decode; any strobe pattern other than byte/half is handled as a word.
    always_comb begin
        case (cpu_wstrobe)
            4'b0001: req_size = SZ_BYTE;
            4'b0011: req_size = SZ_HALF;
            default: req_size = SZ_WORD;
        endcase
        case (req_size)
            SZ_BYTE: req_strb = 4'b0001;
            SZ_HALF: req_strb = 4'b0011;
            default: req_strb = 4'b1111;
        endcase
        misaligned = ((req_size == SZ_HALF) && cpu_addr[0]) ||
                     ((req_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00));
    end

    // Right-align the addressed lanes of the bus word and zero-fill above size.
    always_comb begin
        rsp_shifted = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_BYTE: load_data = {24'h0, rsp_shifted[7:0]};
            SZ_HALF: load_data = {16'h0, rsp_shifted[15:0]};
            default: load_data = rsp_shifted;
        endcase
    end

    // The counter value after this cycle; the abort fires on the cycle that
    // brings it to TIMEOUT_CYCLES, so REQ+RESP last at most TIMEOUT_CYCLES.
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign tout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d       = state_q;
        bus_addr_d    = bus_addr_q;
        bus_we_d      = bus_we_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wstrb_d   = bus_wstrb_q;
        size_d        = size_q;
        off_d         = off_q;
        cnt_d         = cnt_q;
        cpu_rdata_d   = cpu_rdata_q;
        tout_d        = tout_q;
        err_sticky_d  = err_sticky_q;
        cpu_stall     = 1'b0;
        cpu_err       = 1'b0;
        bus_req_valid = 1'b0;

        case (state_q)
            IDLE: begin
                tout_d = 1'b0;
                if (cpu_req) begin
                    if (misaligned) begin
                        // Fault without touching the bus; the core sees it this cycle.
                        cpu_err      = 1'b1;
                        err_sticky_d = 1'b1;
                    end else begin
                        cpu_stall   = 1'b1;
                        bus_addr_d  = {cpu_addr[31:2], 2'b00};
                        bus_we_d    = cpu_we;
                        bus_wdata_d = cpu_wdata << {cpu_addr[1:0], 3'b000};
                        bus_wstrb_d = cpu_we ? (req_strb << cpu_addr[1:0]) : 4'b0000;
                        size_d      = req_size;
                        off_d       = cpu_addr[1:0];
                        cnt_d       = '0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                cpu_stall     = 1'b1;
                bus_req_valid = 1'b1;
                cnt_d         = cnt_inc;
                // A handshake on the abort cycle wins: the bus has taken it.
                if (bus_req_ready) begin
                    state_d = RESP;
                end else if (tout_hit) begin
                    cpu_rdata_d  = '0;
                    tout_d       = 1'b1;
                    err_sticky_d = 1'b1;
                    state_d      = DONE;
                end
            end
            RESP: begin
                cpu_stall = 1'b1;
                cnt_d     = cnt_inc;
                if (bus_rsp_valid) begin
                    cpu_rdata_d = bus_we_q ? 32'h0 : load_data;
                    state_d     = DONE;
                end else if (tout_hit) begin
                    cpu_rdata_d  = '0;
                    tout_d       = 1'b1;
                    err_sticky_d = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                // Core commits on this edge; a new request is taken from IDLE.
                cpu_err = tout_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q      <= IDLE;
            bus_addr_q   <= '0;
            bus_we_q     <= 1'b0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            size_q       <= SZ_BYTE;
            off_q        <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            tout_q       <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_addr_q   <= bus_addr_d;
            bus_we_q     <= bus_we_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            size_q       <= size_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            tout_q       <= tout_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign err_sticky = err_sticky_q;
    assign bus_addr   = bus_addr_q;
    assign bus_we     = bus_we_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_wstrb  = bus_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_bus_bridge
// Description : Self-checking bench for lsu_bus_bridge. A table of directed
//               load/store records (bus lane expectations, load result,
//               stall length) runs back to back, followed by hand-written
//               sequences for misalignment, timeout and mid-access reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_bridge;

    logic        clk;
    logic        nreset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrobe;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        err_sticky;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    lsu_bus_bridge #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_wstrobe  (cpu_wstrobe),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_err      (cpu_err),
        .err_sticky   (err_sticky),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] brdata;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdata;
        int          e_stall;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic [31:0] brdata, input int rdy_dly,
                                input int rsp_dly, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                                input logic [31:0] e_rdata, input int e_stall);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.brdata = brdata; v.rdy_dly = rdy_dly; v.rsp_dly = rsp_dly;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
        v.e_rdata = e_rdata; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one access from the IDLE cycle through DONE. The bus side reacts
    // to bus_req_valid with the record's ready/response delays.
    task automatic run_access(input vec_t v, input string tag, input logic e_sticky);
        int  stall_cnt = 0;
        int  req_cyc   = 0;
        int  resp_cyc  = 0;
        bit  accepted  = 0;
        bit  seen_req  = 0;
        bit  done      = 0;
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_we      = v.we;
        cpu_addr    = v.addr;
        cpu_wdata   = v.wdata;
        cpu_wstrobe = v.strb;
        bus_rdata   = v.brdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            if (bus_req_valid) begin
                if (!seen_req) begin
                    seen_req = 1;
                    check({tag, "_bus_addr"},  bus_addr, v.e_addr);
                    check({tag, "_bus_we"},    {31'h0, bus_we}, {31'h0, v.we});
                    check({tag, "_bus_wdata"}, bus_wdata, v.e_wdata);
                    check({tag, "_bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.e_wstrb});
                end
                if (req_cyc >= v.rdy_dly) begin
                    bus_req_ready = 1'b1;
                    accepted = 1;
                end
                req_cyc++;
            end else if (accepted) begin
                if (resp_cyc >= v.rsp_dly) bus_rsp_valid = 1'b1;
                resp_cyc++;
            end
            #1;
            if (cpu_stall) begin
                stall_cnt++;
                @(negedge clk);
            end else begin
                done = 1;
                check({tag, "_rdata"},  cpu_rdata, v.e_rdata);
                check({tag, "_err"},    {31'h0, cpu_err}, 32'h0);
                check({tag, "_stalls"}, stall_cnt, v.e_stall);
                check({tag, "_sticky"}, {31'h0, err_sticky}, {31'h0, e_sticky});
            end
        end
        check({tag, "_completed"}, {31'h0, done}, 32'h1);
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
    endtask

    initial begin
        int  vcnt;
        bit  done;
        nreset        = 1'b0;
        cpu_req       = 1'b0;
        cpu_we        = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        cpu_wstrobe   = '0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = '0;

        //             we    addr          wdata         strb     bus_rdata     rdy rsp e_addr        e_wdata       e_wstrb  e_rdata       stall
        vecs[0] = mk(1'b0, 32'h80001000, 32'h00000000, 4'b1111, 32'hDEADBEEF, 1, 0, 32'h80001000, 32'h00000000, 4'b0000, 32'hDEADBEEF, 4);
        vecs[1] = mk(1'b1, 32'h80001002, 32'h000000AB, 4'b0001, 32'h12345678, 0, 0, 32'h80001000, 32'h00AB0000, 4'b0100, 32'h00000000, 3);
        vecs[2] = mk(1'b0, 32'h80001002, 32'h00000000, 4'b0011, 32'hBEEF1234, 0, 0, 32'h80001000, 32'h00000000, 4'b0000, 32'h0000BEEF, 3);
        vecs[3] = mk(1'b0, 32'h80001003, 32'h00000000, 4'b0001, 32'h80FFFFFF, 0, 0, 32'h80001000, 32'h00000000, 4'b0000, 32'h00000080, 3);
        vecs[4] = mk(1'b1, 32'h80001002, 32'hFFFF1234, 4'b0011, 32'hFFFFFFFF, 2, 1, 32'h80001000, 32'h12340000, 4'b1100, 32'h00000000, 6);
        vecs[5] = mk(1'b1, 32'h80001004, 32'hCAFEF00D, 4'b1111, 32'h00000000, 0, 0, 32'h80001004, 32'hCAFEF00D, 4'b1111, 32'h00000000, 3);
        vecs[6] = mk(1'b0, 32'h80001001, 32'h00000000, 4'b0001, 32'h1122C344, 0, 2, 32'h80001000, 32'h00000000, 4'b0000, 32'h000000C3, 5);
        vecs[7] = mk(1'b0, 32'h80001008, 32'h00000000, 4'b0111, 32'h01020304, 0, 0, 32'h80001008, 32'h00000000, 4'b0000, 32'h01020304, 3);
        vecs[8] = mk(1'b1, 32'h8000100C, 32'h55AA55AA, 4'b0010, 32'h00000000, 1, 0, 32'h8000100C, 32'h55AA55AA, 4'b1111, 32'h00000000, 4);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall",  {31'h0, cpu_stall},     32'h0);
        check("rst_err",    {31'h0, cpu_err},       32'h0);
        check("rst_sticky", {31'h0, err_sticky},    32'h0);
        check("rst_valid",  {31'h0, bus_req_valid}, 32'h0);
        check("rst_rdata",  cpu_rdata,              32'h0);
        check("rst_baddr",  bus_addr,               32'h0);
        @(negedge clk);
        nreset = 1'b1;

        // Table: accesses issued back to back in the IDLE cycle after DONE
        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i], $sformatf("v%0d", i), 1'b0);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("idle_after_table_stall", {31'h0, cpu_stall}, 32'h0);

        // Misaligned word: error the same cycle, no stall, no bus request
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80001002; cpu_wstrobe = 4'b1111;
        #1;
        check("mis_w_err",    {31'h0, cpu_err},       32'h1);
        check("mis_w_stall",  {31'h0, cpu_stall},     32'h0);
        check("mis_w_valid",  {31'h0, bus_req_valid}, 32'h0);
        check("mis_w_sticky0",{31'h0, err_sticky},    32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("mis_w_sticky1",{31'h0, err_sticky},    32'h1);
        check("mis_w_valid2", {31'h0, bus_req_valid}, 32'h0);
        // Misaligned half
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80001001; cpu_wstrobe = 4'b0011;
        #1;
        check("mis_h_err",    {31'h0, cpu_err},   32'h1);
        check("mis_h_stall",  {31'h0, cpu_stall}, 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("mis_h_valid",  {31'h0, bus_req_valid}, 32'h0);

        // Reset clears the sticky flag; then a load leaves nonzero rdata behind
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("rst2_sticky", {31'h0, err_sticky}, 32'h0);
        run_access(vecs[0], "pre_to", 1'b0);

        // Timeout: ready never arrives
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80002000; cpu_wstrobe = 4'b1111;
        bus_req_ready = 1'b0;
        vcnt = 0;
        done = 0;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            #1;
            if (bus_req_valid) vcnt++;
            if (!cpu_stall) begin
                done = 1;
                check("to_err",    {31'h0, cpu_err},    32'h1);
                check("to_rdata",  cpu_rdata,           32'h0);
                check("to_sticky", {31'h0, err_sticky}, 32'h1);
                check("to_valid",  {31'h0, bus_req_valid}, 32'h0);
                check("to_vcycles", vcnt, 8);
            end else begin
                @(negedge clk);
            end
        end
        check("to_completed", {31'h0, done}, 32'h1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("to_idle_err", {31'h0, cpu_err}, 32'h0);

        // Reset while waiting in RESP; a late response must be ignored
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80003004; cpu_wstrobe = 4'b1111;
        bus_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        #1;
        check("mr_valid_req", {31'h0, bus_req_valid}, 32'h1);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        #1;
        check("mr_in_resp_stall", {31'h0, cpu_stall}, 32'h1);
        nreset  = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("mr_stall",  {31'h0, cpu_stall},     32'h0);
        check("mr_valid",  {31'h0, bus_req_valid}, 32'h0);
        check("mr_baddr",  bus_addr,               32'h0);
        check("mr_rdata",  cpu_rdata,              32'h0);
        @(negedge clk);
        bus_rsp_valid = 1'b1;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("mr_late_stall%0d", k), {31'h0, cpu_stall}, 32'h0);
            check($sformatf("mr_late_err%0d", k),   {31'h0, cpu_err},   32'h0);
            check($sformatf("mr_late_rdata%0d", k), cpu_rdata,          32'h0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
